// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequences one RV32I ALU instruction at a time through
// decode, register read, ALU execute and write-back, with illegal-opcode
// drop, ALU hang timeout, flush and a retired-instruction counter.
module alu_issue_ctrl #(
   parameter int unsigned ALU_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [31:0] instr,
   input  logic        flush,
   output logic [31:0] dec_instr,
   input  logic [4:0]  dec_alu_op,
   input  logic        dec_reg_write,
   input  logic        dec_alu_src,
   input  logic [4:0]  dec_rs1,
   input  logic [4:0]  dec_rs2,
   input  logic [4:0]  dec_rd,
   input  logic [31:0] dec_imm,
   output logic        rf_rd_en,
   output logic [4:0]  rf_rs1,
   output logic [4:0]  rf_rs2,
   input  logic [31:0] rf_rdata1,
   input  logic [31:0] rf_rdata2,
   output logic        alu_start,
   output logic [4:0]  alu_op,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic        alu_done,
   input  logic [31:0] alu_result,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        illegal,
   output logic        timeout,
   output logic        busy,
   output logic [31:0] retired_cnt
);

   localparam int unsigned CNT_W = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DECODE = 3'd1,
      S_READ   = 3'd2,
      S_OPND   = 3'd3,
      S_EXEC   = 3'd4,
      S_WB     = 3'd5
   } state_t;

   state_t           r_state;
   logic [31:0]      r_instr_q;
   logic [4:0]       r_alu_op;
   logic             r_alu_src;
   logic [4:0]       r_rs1;
   logic [4:0]       r_rs2;
   logic [4:0]       r_rd;
   logic [31:0]      r_imm;
   logic [31:0]      r_a;
   logic [31:0]      r_b;
   logic             r_rf_rd_en;
   logic             r_alu_start;
   logic             r_rf_we;
   logic [4:0]       r_waddr;
   logic [31:0]      r_wdata;
   logic             r_illegal;
   logic             r_timeout;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_retired_cnt;

   // Issue FSM with all datapath registers and one-cycle strobes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_instr_q     <= '0;
         r_alu_op      <= '0;
         r_alu_src     <= 1'b0;
         r_rs1         <= '0;
         r_rs2         <= '0;
         r_rd          <= '0;
         r_imm         <= '0;
         r_a           <= '0;
         r_b           <= '0;
         r_rf_rd_en    <= 1'b0;
         r_alu_start   <= 1'b0;
         r_rf_we       <= 1'b0;
         r_waddr       <= '0;
         r_wdata       <= '0;
         r_illegal     <= 1'b0;
         r_timeout     <= 1'b0;
         r_cnt         <= '0;
         r_retired_cnt <= '0;
      end else begin
         r_rf_rd_en  <= 1'b0;
         r_alu_start <= 1'b0;
         r_rf_we     <= 1'b0;
         r_illegal   <= 1'b0;
         r_timeout   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (instr_valid) begin
                  r_instr_q <= instr;
                  r_state   <= S_DECODE;
               end
            end
            S_DECODE: begin
               r_alu_op  <= dec_alu_op;
               r_alu_src <= dec_alu_src;
               r_rs1     <= dec_rs1;
               r_rs2     <= dec_rs2;
               r_rd      <= dec_rd;
               r_imm     <= dec_imm;
               if (flush) begin
                  r_state <= S_IDLE;
               end else if (!dec_reg_write) begin
                  r_illegal <= 1'b1;
                  r_state   <= S_IDLE;
               end else begin
                  r_rf_rd_en <= 1'b1;
                  r_state    <= S_READ;
               end
            end
            S_READ: begin
               r_state <= flush ? S_IDLE : S_OPND;
            end
            S_OPND: begin
               r_a <= rf_rdata1;
               r_b <= r_alu_src ? r_imm : rf_rdata2;
               if (flush) begin
                  r_state <= S_IDLE;
               end else begin
                  r_alu_start <= 1'b1;
                  r_cnt       <= '0;
                  r_state     <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (flush) begin
                  r_state <= S_IDLE;
               end else if (alu_done) begin
                  r_wdata <= alu_result;
                  r_waddr <= r_rd;
                  r_rf_we <= (r_rd != 5'd0);
                  r_state <= S_WB;
               end else if (r_cnt == CNT_LAST) begin
                  r_timeout <= 1'b1;
                  r_state   <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_WB: begin
               // rf_we is a registered strobe already on the bus; a flush here only withholds the retire
               if (!flush) begin
                  r_retired_cnt <= r_retired_cnt + 32'd1;
               end
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Outputs driven straight from registers or decoded from state
   assign instr_ready = (r_state == S_IDLE);
   assign busy        = (r_state != S_IDLE);
   assign dec_instr   = r_instr_q;
   assign rf_rd_en    = r_rf_rd_en;
   assign rf_rs1      = r_rs1;
   assign rf_rs2      = r_rs2;
   assign alu_start   = r_alu_start;
   assign alu_op      = r_alu_op;
   assign alu_a       = r_a;
   assign alu_b       = r_b;
   assign rf_we       = r_rf_we;
   assign rf_waddr    = r_waddr;
   assign rf_wdata    = r_wdata;
   assign illegal     = r_illegal;
   assign timeout     = r_timeout;
   assign retired_cnt = r_retired_cnt;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: behavioural decoder, register file and ALU
// around the DUT, with a per-instruction outcome/timing reference model.
module tb_alu_issue_ctrl;

   localparam int unsigned AT = 4;

   logic        clk;
   logic        rst_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic        flush;
   logic [31:0] dec_instr;
   logic [4:0]  dec_alu_op;
   logic        dec_reg_write;
   logic        dec_alu_src;
   logic [4:0]  dec_rs1;
   logic [4:0]  dec_rs2;
   logic [4:0]  dec_rd;
   logic [31:0] dec_imm;
   logic        rf_rd_en;
   logic [4:0]  rf_rs1;
   logic [4:0]  rf_rs2;
   logic [31:0] rf_rdata1;
   logic [31:0] rf_rdata2;
   logic        alu_start;
   logic [4:0]  alu_op;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic        alu_done;
   logic [31:0] alu_result;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        illegal;
   logic        timeout;
   logic        busy;
   logic [31:0] retired_cnt;

   logic [31:0] regs [32];
   logic [31:0] model_cnt;
   int          total;
   int          bad;

   alu_issue_ctrl #(.ALU_TIMEOUT(AT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr        (instr),
      .flush        (flush),
      .dec_instr    (dec_instr),
      .dec_alu_op   (dec_alu_op),
      .dec_reg_write(dec_reg_write),
      .dec_alu_src  (dec_alu_src),
      .dec_rs1      (dec_rs1),
      .dec_rs2      (dec_rs2),
      .dec_rd       (dec_rd),
      .dec_imm      (dec_imm),
      .rf_rd_en     (rf_rd_en),
      .rf_rs1       (rf_rs1),
      .rf_rs2       (rf_rs2),
      .rf_rdata1    (rf_rdata1),
      .rf_rdata2    (rf_rdata2),
      .alu_start    (alu_start),
      .alu_op       (alu_op),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_done     (alu_done),
      .alu_result   (alu_result),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .illegal      (illegal),
      .timeout      (timeout),
      .busy         (busy),
      .retired_cnt  (retired_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RV32I integer semantics for one funct3 / alternate-bit pair
   function automatic logic [31:0] rv_op(input logic [2:0] f3, input logic alt,
                                         input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0:    return alt ? (a - b) : (a + b);
         3'd1:    return a << b[4:0];
         3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3:    return (a < b) ? 32'd1 : 32'd0;
         3'd4:    return a ^ b;
         3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
         3'd6:    return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic logic is_alt(input logic [31:0] ins);
      return ins[30] && ((ins[6:0] == 7'h33) || (ins[14:12] == 3'd5));
   endfunction

   // Decoder stand-in: op code is funct3+1, plus 8 for SUB/SRA
   assign dec_reg_write = (dec_instr[6:0] == 7'h13) || (dec_instr[6:0] == 7'h33);
   assign dec_alu_src   = (dec_instr[6:0] == 7'h13);
   assign dec_rs1       = dec_instr[19:15];
   assign dec_rs2       = dec_instr[24:20];
   assign dec_rd        = dec_instr[11:7];
   assign dec_imm       = {{20{dec_instr[31]}}, dec_instr[31:20]};
   assign dec_alu_op    = 5'(dec_instr[14:12]) + 5'd1 + (is_alt(dec_instr) ? 5'd8 : 5'd0);

   // ALU stand-in decodes the op back into funct3 / alternate bit
   logic [4:0] alu_idx;
   assign alu_idx    = alu_op - 5'd1;
   assign alu_result = rv_op(alu_idx[2:0], alu_idx[3], alu_a, alu_b);

   // Register file stand-in: data valid the cycle after rf_rd_en, garbage otherwise
   always_ff @(posedge clk) begin
      if (rf_rd_en) begin
         rf_rdata1 <= regs[rf_rs1];
         rf_rdata2 <= regs[rf_rs2];
      end else begin
         rf_rdata1 <= $urandom;
         rf_rdata2 <= $urandom;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   function automatic logic happens(input int e, input int f);
      return (f < 1) || (f >= e);
   endfunction

   // Offer one instruction at the current negedge and check it cycle by cycle.
   // lat: ALU done this many cycles after alu_start (lat >= AT never answers).
   // f: cycle (relative to accept) with flush high, -1 for none.
   task automatic run_instr(input logic [31:0] ins, input int lat, input int f);
      logic        legal;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        retire;
      int          wb;
      int          to_c;
      int          nat_end;
      int          end_c;
      legal = (ins[6:0] == 7'h13) || (ins[6:0] == 7'h33);
      rd    = ins[11:7];
      imm   = {{20{ins[31]}}, ins[31:20]};
      a     = regs[ins[19:15]];
      b     = (ins[6:0] == 7'h13) ? imm : regs[ins[24:20]];
      res   = rv_op(ins[14:12], is_alt(ins), a, b);
      wb    = -1;
      to_c  = -1;
      if (!legal) begin
         nat_end = 2;
      end else if (lat < int'(AT)) begin
         wb      = 5 + lat;
         nat_end = 6 + lat;
      end else begin
         to_c    = 4 + int'(AT);
         nat_end = 4 + int'(AT);
      end
      end_c  = (f >= 1 && f + 1 < nat_end) ? f + 1 : nat_end;
      retire = legal && (wb > 0) && !(f >= 1 && f <= wb);

      chk("accept_ready", 32'(instr_ready), 32'd1);
      instr_valid = 1'b1;
      instr       = ins;
      flush       = (f == 0);
      alu_done    = 1'b0;
      for (int k = 1; k <= end_c; k++) begin
         @(negedge clk);
         instr_valid = 1'b0;
         instr       = $urandom;
         if (k == 1) chk("dec_instr", dec_instr, ins);
         chk("busy", 32'(busy), 32'(k < end_c));
         chk("rf_rd_en", 32'(rf_rd_en), 32'(legal && k == 2 && happens(2, f)));
         chk("alu_start", 32'(alu_start), 32'(legal && k == 4 && happens(4, f)));
         chk("illegal", 32'(illegal), 32'(!legal && k == 2 && happens(2, f)));
         chk("timeout", 32'(timeout), 32'(k == to_c && happens(to_c, f)));
         if (!(k == wb && f == wb))
            chk("rf_we", 32'(rf_we), 32'(k == wb && rd != 5'd0 && happens(wb, f)));
         if (legal && k == 2 && happens(2, f)) begin
            chk("rf_rs1", 32'(rf_rs1), 32'(ins[19:15]));
            chk("rf_rs2", 32'(rf_rs2), 32'(ins[24:20]));
         end
         if (legal && k >= 4 && k < end_c && k < ((wb < 0) ? to_c : wb)) begin
            chk("alu_a", alu_a, a);
            chk("alu_b", alu_b, b);
            chk("alu_op", 32'(alu_op), 32'(5'(ins[14:12]) + 5'd1 + (is_alt(ins) ? 5'd8 : 5'd0)));
         end
         if (k == wb && rd != 5'd0 && happens(wb, f) && f != wb) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(rd));
            chk("rf_wdata", rf_wdata, res);
         end
         flush    = (k == f);
         alu_done = (legal && lat < int'(AT) && k == 4 + lat) ||
                    (k < 4 && $urandom_range(0, 1) == 1);
      end
      flush    = 1'b0;
      alu_done = 1'b0;
      if (retire) model_cnt = model_cnt + 32'd1;
      chk("end_ready", 32'(instr_ready), 32'd1);
      chk("retired_cnt", retired_cnt, model_cnt);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_strobes"}, 32'({rf_rd_en, alu_start, rf_we, illegal, timeout, busy}), 32'd0);
      chk({tag, "_ready"}, 32'(instr_ready), 32'd1);
      chk({tag, "_dec_instr"}, dec_instr, 32'd0);
      chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
      chk({tag, "_alu_a"}, alu_a, 32'd0);
      chk({tag, "_alu_b"}, alu_b, 32'd0);
      chk({tag, "_rf_rs"}, 32'({rf_rs1, rf_rs2, rf_waddr}), 32'd0);
      chk({tag, "_rf_wdata"}, rf_wdata, 32'd0);
      chk({tag, "_retired"}, retired_cnt, 32'd0);
   endtask

   // Abort if anything stalls the stimulus process
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [6:0] bad_ops [4];
      logic [31:0] r;
      logic [6:0]  opc;
      int          sel;
      int          lat;
      int          f;
      total = 0;
      bad   = 0;
      bad_ops[0] = 7'h73;
      bad_ops[1] = 7'h03;
      bad_ops[2] = 7'h23;
      bad_ops[3] = 7'h6f;
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      regs[0] = 32'd0;
      regs[1] = 32'd10;
      regs[2] = 32'd20;
      rst_n       = 1'b0;
      instr_valid = 1'b0;
      instr       = 32'd0;
      flush       = 1'b0;
      alu_done    = 1'b0;
      model_cnt   = 32'd0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      run_instr(32'h0070_0293, 0, -1);        // ADDI x5,x0,7
      run_instr(32'h0020_81b3, 2, -1);        // ADD x3,x1,x2, three EXEC cycles
      run_instr(32'h0000_0073, 0, -1);        // unsupported opcode
      run_instr(32'h0020_81b3, int'(AT), -1); // ALU never answers
      run_instr(32'h0010_0013, 0, -1);        // ADDI x0,x0,1
      run_instr(32'h0020_81b3, int'(AT), 5);  // flush during EXEC
      run_instr(32'h0020_81b3, 1, 6);         // flush during WB
      run_instr(32'h0030_8213, 0, 0);         // flush while idle, same-cycle accept

      for (int n = 0; n < 60; n++) begin
         r   = $urandom;
         sel = $urandom_range(0, 9);
         if (sel < 4)      opc = 7'h13;
         else if (sel < 8) opc = 7'h33;
         else              opc = bad_ops[$urandom_range(0, 3)];
         lat = $urandom_range(0, int'(AT));
         f   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 10) : -1;
         run_instr({r[31:7], opc}, lat, f);
      end

      // Synchronous reset in the middle of EXEC
      chk("rst_accept_ready", 32'(instr_ready), 32'd1);
      instr_valid = 1'b1;
      instr       = 32'h0020_81b3;
      @(negedge clk);
      instr_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_pre_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk_reset_outputs("exec_reset");
      rst_n     = 1'b1;
      model_cnt = 32'd0;
      @(negedge clk);

      // Retired counter wrap from all-ones
      force dut.r_retired_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.r_retired_cnt;
      model_cnt = 32'hFFFF_FFFF;
      run_instr(32'h0070_0293, 0, -1);
      chk("wrap_zero", retired_cnt, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
